// File: rtl/irq_pkg.sv
// Shared definitions for the Wishbone interrupt controller: register map,
// source limits and the STATUS word layout.
package irq_pkg;

  localparam int unsigned IRQ_MAX_SRC = 32;
  localparam int unsigned IRQ_DATA_W  = 32;
  localparam int unsigned IRQ_ADDR_W  = 2;
  localparam int unsigned IRQ_IDX_W   = 5;

  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_PENDING = 2'b00;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_ENABLE  = 2'b01;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_MODE    = 2'b10;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_STATUS  = 2'b11;

  localparam int unsigned IRQ_STATUS_VALID_BIT = 31;
  localparam int unsigned IRQ_STATUS_IDX_LSB   = 0;

  // STATUS read word: {valid, reserved, index}
  typedef struct packed {
    logic                 valid;
    logic [25:0]          rsvd;
    logic [IRQ_IDX_W-1:0] index;
  } irq_status_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder; bit 0 is the highest priority.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 valid_c,
  output logic [IRQ_IDX_W-1:0] index_c
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    valid_c = 1'b0;
    index_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid_c = 1'b1;
        index_c = IRQ_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_wb.sv
// Wishbone interrupt controller: edge/level sources, W1C pending, enable mask,
// priority STATUS. Define IRQ_WB_SYNC_EN to add a 2-flop input synchroniser.
module irq_wb
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC    = 8,
  parameter logic [31:0] RST_MODE = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IRQ_ADDR_W-1:0] wb_addr,
  output logic [IRQ_DATA_W-1:0] wb_rdata,
  input  logic [IRQ_DATA_W-1:0] wb_wdata,
  input  logic                  wb_we,
  input  logic                  wb_cyc,
  output logic                  wb_ack,
  input  logic [N_SRC-1:0]      irq_src,
  output logic                  irq
);

  localparam logic [N_SRC-1:0] MODE_RST = RST_MODE[N_SRC-1:0];

  logic [N_SRC-1:0]      src_s;
  logic [N_SRC-1:0]      prev_q;
  logic [N_SRC-1:0]      pend_q;
  logic [N_SRC-1:0]      en_q;
  logic [N_SRC-1:0]      mode_q;
  logic [N_SRC-1:0]      mode_nxt_c;
  logic [N_SRC-1:0]      w1c_c;
  logic [N_SRC-1:0]      rise_c;
  logic [N_SRC-1:0]      pend_c;
  logic [N_SRC-1:0]      act_c;
  logic                  acc_c;
  logic                  wr_stb_q;
  logic [IRQ_ADDR_W-1:0] wr_addr_q;
  logic [N_SRC-1:0]      wr_data_q;
  logic [IRQ_DATA_W-1:0] rd_mux_c;
  logic                  act_valid_c;
  logic [IRQ_IDX_W-1:0]  act_idx_c;
  irq_status_t           status_c;
  logic                  unused_wdata;

  // Only the low N_SRC write-data bits are meaningful.
  assign unused_wdata = ^wb_wdata;

`ifdef IRQ_WB_SYNC_EN
  logic [N_SRC-1:0] sync1_q;
  logic [N_SRC-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src;
`endif

  // Bus handshake: one ack per access, a new access every second clock.
  assign acc_c = wb_cyc & ~wb_ack;

  assign status_c = '{valid: act_valid_c, rsvd: '0, index: act_idx_c};

  always_comb begin
    rd_mux_c = '0;
    case (wb_addr)
      IRQ_ADDR_PENDING: rd_mux_c = IRQ_DATA_W'(pend_c);
      IRQ_ADDR_ENABLE:  rd_mux_c = IRQ_DATA_W'(en_q);
      IRQ_ADDR_MODE:    rd_mux_c = IRQ_DATA_W'(mode_q);
      IRQ_ADDR_STATUS:  rd_mux_c = status_c;
      default:          rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack    <= 1'b0;
      wb_rdata  <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wb_ack   <= acc_c;
      wb_rdata <= acc_c ? rd_mux_c : '0;
      wr_stb_q <= acc_c & wb_we;
      if (acc_c) begin
        wr_addr_q <= wb_addr;
        wr_data_q <= wb_wdata[N_SRC-1:0];
      end
    end
  end

  // Registered write strobe lands one clock after the ack.
  assign mode_nxt_c = (wr_stb_q && wr_addr_q == IRQ_ADDR_MODE) ? wr_data_q : mode_q;
  assign w1c_c      = (wr_stb_q && wr_addr_q == IRQ_ADDR_PENDING) ? wr_data_q : '0;
  assign rise_c     = src_s & ~prev_q;

  assign pend_c = (mode_q & pend_q) | (~mode_q & src_s);
  assign act_c  = pend_c & en_q;

  // Set beats clear; masking with the next MODE drops bits turning level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= MODE_RST;
      irq    <= 1'b0;
    end else begin
      prev_q <= src_s;
      pend_q <= ((pend_q & ~w1c_c) | rise_c) & mode_nxt_c;
      mode_q <= mode_nxt_c;
      if (wr_stb_q && wr_addr_q == IRQ_ADDR_ENABLE) begin
        en_q <= wr_data_q;
      end
      irq <= |act_c;
    end
  end

  irq_prio_enc #(
    .N (N_SRC)
  ) u_prio_enc (
    .req     (act_c),
    .valid_c (act_valid_c),
    .index_c (act_idx_c)
  );

endmodule

// File: doc/irq_wb.md
# irq_wb

Wishbone-attached interrupt controller that collects event lines from peripheral blocks (the timer's event output, button and UART events) and presents one masked interrupt request to the CPU. It latches edge-type sources into write-1-to-clear pending bits, passes level-type sources through, applies a per-source enable mask and reports the highest-priority active source. It shares the bus-slave handshake of the other `_wb` peripherals on the SoC bus.

## Interface
- `N_SRC`, 8, number of interrupt sources, legal range 1..32.
- `RST_MODE`, 32'hFFFFFFFF, reset value of MODE; bit=1 is edge, bit=0 is level. Only the low `N_SRC` bits are used.
- `clk`  input  1  system clock. One clock; reset is asynchronous and active-low.
- `rst_n`  input  1  asynchronous active-low reset.
- `wb_addr`  input  2  register select.
- `wb_rdata`  output  32  read data, zero outside a read ack.
- `wb_wdata`  input  32  write data.
- `wb_we`  input  1  write enable.
- `wb_cyc`  input  1  cycle/strobe.
- `wb_ack`  output  1  single-cycle acknowledge.
- `irq_src`  input  N_SRC  raw event lines, active-high.
- `irq`  output  1  registered interrupt request to the CPU.

## Operation
- Register map (unused bits read 0, writes to them ignored):
  - 2'b00 PENDING: read effective pending. Write 1 clears edge-mode bits; write 0 has no effect; level-mode bits ignore writes.
  - 2'b01 ENABLE: read/write mask, reset 0.
  - 2'b10 MODE: read/write, reset `RST_MODE`.
  - 2'b11 STATUS: read-only, `{valid[31], 26'b0, index[4:0]}`. Writes ignored.
- `src_s` is `irq_src` after optional synchronisation (see Configuration).
- Edge detect: `prev` register samples `src_s` every cycle regardless of mode. `rise = src_s & ~prev`.
- Edge-mode pending flop: set on `rise`, cleared by a W1C write. Set and clear in the same cycle: set wins.
- Effective pending: `pend = (MODE & pend_q) | (~MODE & src_s)`.
- Active: `act = pend & ENABLE`. `irq` is registered `|act`.
- STATUS: `index` is the lowest set bit of `act` (bit 0 has highest priority). `valid = |act`. When `valid = 0`, `index = 0`. STATUS is combinational from the current registers and sampled into `wb_rdata`.
- Mode change edge→level: `pend_q` for that bit is cleared in the same cycle the MODE write lands. Level→edge: no spurious pending, because `prev` tracks continuously.

## Timing
- Reset values: `wb_ack=0`, `wb_rdata=0`, `irq=0`, `pend_q=0`, `prev=0`, sync flops 0, ENABLE 0, MODE `RST_MODE`.
- Handshake: `ack <= wb_cyc & ~ack`.
  - Each access acks on the edge after `wb_cyc` rises.
  - Back-to-back cycles ack every second clock.
- Read: `wb_rdata` is loaded on the same edge that raises `ack`. It is forced to 0 whenever `~wb_cyc | ack`.
- Write: a strobe is registered with `ack`, blocked while `ack=1`. The target register updates on the following edge, i.e. 2 clocks after `wb_cyc` rises.
- Latency from the `irq_src` rising edge to `irq` high, with the source enabled:
  - 2 clocks without the synchroniser (`prev`/`pend_q`, then `irq`).
  - 4 clocks with it.
- W1C of the sole pending bit: `irq` falls 1 clock after `pend_q` clears.
- Reset asserted mid-transaction: `ack` and `rdata` drop immediately and the access is lost.

## Configuration
- `IRQ_WB_SYNC_EN` defined: a 2-flop synchroniser on every `irq_src` bit adds 2 cycles of latency. Use it for sources from other clock domains or pads.
- Undefined: `src_s = irq_src` directly. Sources must then be synchronous to `clk`.

## Structure
- Shared package `irq_pkg`:
  - address localparams `IRQ_ADDR_PENDING/ENABLE/MODE/STATUS`;
  - `IRQ_MAX_SRC = 32`;
  - STATUS bit-position constants.
- Sub-module `irq_prio_enc`: parameterised `N` lowest-set-bit encoder producing `valid` and a 5-bit `index`. Pure combinational; instantiated once.
- Index width is fixed at 5 bits regardless of `N_SRC`.

## Test plan
- Reset, then read all four registers → PENDING 0, ENABLE 0, MODE 0xFF (N_SRC=8), STATUS 0; `irq=0`.
- MODE=0xFF, ENABLE=0x04, pulse `irq_src[2]` for 1 clock → PENDING=0x04, `irq=1` 2 clocks after the pulse (no sync), STATUS=0x80000002. Write PENDING=0x04 → `irq=0`, PENDING=0.
- ENABLE=0x0A, pulse sources 3 and 1 together → STATUS index 1. W1C bit 1 → index 3, valid 1.
- MODE=0xFE (bit 0 level), ENABLE=0x01, hold `irq_src[0]` high → PENDING bit 0 follows it. W1C write has no effect. Deassert → `irq` drops 1 clock later.
- Pulse `irq_src[5]` in the same cycle a W1C of bit 5 lands → bit 5 remains pending.
- Rebuild with `IRQ_WB_SYNC_EN`; repeat the pulse-to-irq test → latency 4 clocks.
